// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Controls the MEM stage of the pipeline. It issues data-cache read/write
// requests for loads and stores sitting in EX/MEM and stalls the front of the
// pipeline while a cache access is outstanding. It also parks the core in a
// sticky halted state once a HALT reaches MEM/WB, and counts completed loads,
// completed stores and the stall cycles of the most recent access.
//
// Ports
//   CLK        single clock, rising edge
//   RST        asynchronous active-high reset
//   valid_i    EX/MEM holds a real instruction (not a bubble)
//   memread_i  EX/MEM instruction is a load
//   memwrite_i EX/MEM instruction is a store
//   halt_i     EX/MEM instruction is HALT
//   dhit       data cache completes the current access this cycle
//   dREN       data read request to the cache
//   dWEN       data write request to the cache
//   mwen       MEM/WB latch enable
//   mwflush    load a bubble into MEM/WB (meaningful only with mwen=1)
//   stall_o    freeze PC, IF/ID, ID/EX and EX/MEM
//   halt_o     sticky halted indication
//   ld_cnt     completed loads (wraps)
//   st_cnt     completed stores (wraps)
//   wait_cnt   stall cycles of the current or most recent access (saturates)
module mem_stage_ctrl #(
    parameter int CNT_W  = 16,
    parameter int WAIT_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              halt_i,
    input  logic              dhit,
    output logic              dREN,
    output logic              dWEN,
    output logic              mwen,
    output logic              mwflush,
    output logic              stall_o,
    output logic              halt_o,
    output logic [CNT_W-1:0]  ld_cnt,
    output logic [CNT_W-1:0]  st_cnt,
    output logic [WAIT_W-1:0] wait_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Type of the access being waited on: 1 = store, 0 = load.
    logic op_store;
    logic op_store_next;

    logic mop;
    logic ld_done;
    logic st_done;
    logic wait_clear;
    logic wait_load;
    logic wait_inc;

    // A HALT is never treated as a memory op, even if its read/write bits are set.
    assign mop = valid_i & (memread_i | memwrite_i) & ~halt_i;

    // State and latched op type.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            op_store <= 1'b0;
        end else begin
            state    <= state_next;
            op_store <= op_store_next;
        end
    end

    // Next-state and output decode. A read+write conflict is resolved as a
    // store, so dREN is masked by memwrite_i wherever it comes from the inputs.
    always_comb begin
        state_next    = state;
        op_store_next = op_store;
        dREN          = 1'b0;
        dWEN          = 1'b0;
        mwen          = 1'b1;
        mwflush       = 1'b0;
        stall_o       = 1'b0;
        halt_o        = 1'b0;
        ld_done       = 1'b0;
        st_done       = 1'b0;
        wait_clear    = 1'b0;
        wait_load     = 1'b0;
        wait_inc      = 1'b0;

        case (state)
            IDLE: begin
                if (valid_i && halt_i) begin
                    state_next = HALTED;
                end else if (mop) begin
                    dWEN = memwrite_i;
                    dREN = memread_i & ~memwrite_i;
                    if (dhit) begin
                        ld_done    = ~memwrite_i;
                        st_done    = memwrite_i;
                        wait_clear = 1'b1;
                    end else begin
                        mwflush       = 1'b1;
                        stall_o       = 1'b1;
                        wait_load     = 1'b1;
                        op_store_next = memwrite_i;
                        state_next    = ACCESS;
                    end
                end
            end

            // Inputs other than dhit are ignored here: EX/MEM is frozen by stall_o.
            ACCESS: begin
                dWEN = op_store;
                dREN = ~op_store;
                if (dhit) begin
                    ld_done    = ~op_store;
                    st_done    = op_store;
                    state_next = IDLE;
                end else begin
                    mwflush  = 1'b1;
                    stall_o  = 1'b1;
                    wait_inc = 1'b1;
                end
            end

            HALTED: begin
                mwen    = 1'b0;
                stall_o = 1'b1;
                halt_o  = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Completion counters wrap naturally at 2^CNT_W.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else begin
            if (ld_done) begin
                ld_cnt <= ld_cnt + CNT_W'(1);
            end
            if (st_done) begin
                st_cnt <= st_cnt + CNT_W'(1);
            end
        end
    end

    // Stall-cycle counter: the first missed cycle counts as 1, further misses
    // add one each until all-ones, and the value is kept after completion.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt <= '0;
        end else if (wait_clear) begin
            wait_cnt <= '0;
        end else if (wait_load) begin
            wait_cnt <= WAIT_W'(1);
        end else if (wait_inc && !(&wait_cnt)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
// Self-checking bench for mem_stage_ctrl. A behavioural model tracks whether
// the core is halted, whether an access is outstanding (and of which kind),
// and the expected counter values; every cycle the DUT outputs are compared
// against what the model derives from the current inputs.
module tb_mem_stage_ctrl;

    localparam int CNT_W  = 4;
    localparam int WAIT_W = 8;
    localparam int CNT_MOD  = 1 << CNT_W;
    localparam int WAIT_MAX = (1 << WAIT_W) - 1;

    logic              CLK;
    logic              RST;
    logic              valid_i;
    logic              memread_i;
    logic              memwrite_i;
    logic              halt_i;
    logic              dhit;
    logic              dREN;
    logic              dWEN;
    logic              mwen;
    logic              mwflush;
    logic              stall_o;
    logic              halt_o;
    logic [CNT_W-1:0]  ld_cnt;
    logic [CNT_W-1:0]  st_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    int checkCount;
    int errorCount;

    // Reference model state.
    bit m_halted;
    bit m_pending;
    bit m_pend_store;
    int m_ld;
    int m_st;
    int m_wait;

    mem_stage_ctrl #(
        .CNT_W  (CNT_W),
        .WAIT_W (WAIT_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .valid_i    (valid_i),
        .memread_i  (memread_i),
        .memwrite_i (memwrite_i),
        .halt_i     (halt_i),
        .dhit       (dhit),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .mwen       (mwen),
        .mwflush    (mwflush),
        .stall_o    (stall_o),
        .halt_o     (halt_o),
        .ld_cnt     (ld_cnt),
        .st_cnt     (st_cnt),
        .wait_cnt   (wait_cnt)
    );

    // Free-running clock, period 10.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_halted     = 1'b0;
        m_pending    = 1'b0;
        m_pend_store = 1'b0;
        m_ld         = 0;
        m_st         = 0;
        m_wait       = 0;
    endtask

    // Entered and left at posedge+1. Holds reset across one rising edge and
    // checks the cleared values while it is asserted.
    task automatic doReset();
        valid_i    = 1'b0;
        memread_i  = 1'b0;
        memwrite_i = 1'b0;
        halt_i     = 1'b0;
        dhit       = 1'b0;
        RST        = 1'b1;
        #2;
        modelReset();
        checkOutput("rst_ld_cnt",   int'(ld_cnt),   0);
        checkOutput("rst_st_cnt",   int'(st_cnt),   0);
        checkOutput("rst_wait_cnt", int'(wait_cnt), 0);
        checkOutput("rst_halt_o",   int'(halt_o),   0);
        checkOutput("rst_dREN",     int'(dREN),     0);
        checkOutput("rst_dWEN",     int'(dWEN),     0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Drives one cycle of inputs, compares all outputs mid-cycle against the
    // model, then advances the model across the rising edge.
    task automatic applyStimulus(input bit v, input bit r, input bit w, input bit h, input bit d);
        bit mop;
        bit e_dren, e_dwen, e_mwen, e_flush, e_stall, e_halt;
        valid_i    = v;
        memread_i  = r;
        memwrite_i = w;
        halt_i     = h;
        dhit       = d;
        mop = v && (r || w) && !h;

        e_dren = 0; e_dwen = 0; e_mwen = 1; e_flush = 0; e_stall = 0; e_halt = 0;
        if (m_halted) begin
            e_mwen  = 0;
            e_stall = 1;
            e_halt  = 1;
        end else if (m_pending) begin
            e_dwen  = m_pend_store;
            e_dren  = !m_pend_store;
            e_flush = !d;
            e_stall = !d;
        end else if (mop) begin
            e_dwen  = w;
            e_dren  = r && !w;
            e_flush = !d;
            e_stall = !d;
        end

        @(negedge CLK);
        checkOutput("dREN",     int'(dREN),     int'(e_dren));
        checkOutput("dWEN",     int'(dWEN),     int'(e_dwen));
        checkOutput("mwen",     int'(mwen),     int'(e_mwen));
        checkOutput("mwflush",  int'(mwflush),  int'(e_flush));
        checkOutput("stall_o",  int'(stall_o),  int'(e_stall));
        checkOutput("halt_o",   int'(halt_o),   int'(e_halt));
        checkOutput("ld_cnt",   int'(ld_cnt),   m_ld);
        checkOutput("st_cnt",   int'(st_cnt),   m_st);
        checkOutput("wait_cnt", int'(wait_cnt), m_wait);

        @(posedge CLK);
        if (m_halted) begin
            // nothing leaves the halted state except reset
        end else if (m_pending) begin
            if (d) begin
                m_pending = 0;
                if (m_pend_store) m_st = (m_st + 1) % CNT_MOD;
                else              m_ld = (m_ld + 1) % CNT_MOD;
            end else if (m_wait < WAIT_MAX) begin
                m_wait++;
            end
        end else if (v && h) begin
            m_halted = 1;
        end else if (mop) begin
            if (d) begin
                if (w) m_st = (m_st + 1) % CNT_MOD;
                else   m_ld = (m_ld + 1) % CNT_MOD;
                m_wait = 0;
            end else begin
                m_pending    = 1;
                m_pend_store = w;
                m_wait       = 1;
            end
        end
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        RST        = 1'b1;
        valid_i    = 1'b0;
        memread_i  = 1'b0;
        memwrite_i = 1'b0;
        halt_i     = 1'b0;
        dhit       = 1'b0;
        modelReset();
        @(posedge CLK);
        #1;
        doReset();

        // Idle cycle, then a load that hits immediately.
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 1);

        // Store missing three cycles then hitting; inputs in the wait
        // cycles are scrambled to show the latched op drives the cache.
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("store_miss_wait", int'(wait_cnt), 3);
        checkOutput("store_miss_st",   int'(st_cnt),   1);

        // Read/write conflict resolves as a store.
        applyStimulus(1, 1, 1, 0, 1);
        checkOutput("conflict_st", int'(st_cnt), 2);

        // Long load miss saturates the stall counter.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
        end
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("wait_saturated", int'(wait_cnt), WAIT_MAX);

        // Load counter wraps after 2^CNT_W + 1 completions from zero.
        doReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 1, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("ld_wrap", int'(ld_cnt), 1);

        // Reset in the second cycle of a load miss abandons the access.
        applyStimulus(1, 1, 0, 0, 0);
        doReset();
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);

        // Halt, then ten cycles of hits and memory ops that must be ignored.
        applyStimulus(1, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, i[0], !i[0], 0, 1);
        end
        doReset();

        // Randomized traffic with occasional halts and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                doReset();
            end
            applyStimulus($urandom_range(0, 3) != 0,
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 39) == 0,
                          1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the load and store completion counters.
REQ-002 Parameter WAIT_W, default 8: width of the stall-cycle counter.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 valid_i  input  1  EX/MEM latch holds a real instruction, not a bubble.
REQ-006 memread_i  input  1  EX/MEM instruction is a load.
REQ-007 memwrite_i  input  1  EX/MEM instruction is a store.
REQ-008 halt_i  input  1  EX/MEM instruction is HALT.
REQ-009 dhit  input  1  data cache completes the current access this cycle.
REQ-010 dREN  output  1  data read request to the cache.
REQ-011 dWEN  output  1  data write request to the cache.
REQ-012 mwen  output  1  MEM/WB latch enable.
REQ-013 mwflush  output  1  load a bubble into MEM/WB this cycle; valid only with mwen=1.
REQ-014 stall_o  output  1  freeze PC, IF/ID, ID/EX and EX/MEM.
REQ-015 halt_o  output  1  sticky halted indication.
REQ-016 ld_cnt  output  CNT_W  completed loads.
REQ-017 st_cnt  output  CNT_W  completed stores.
REQ-018 wait_cnt  output  WAIT_W  cycles stalled on the current or most recent access.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and HALTED.
REQ-020 A memory op is defined as mop = valid_i & (memread_i | memwrite_i) & ~halt_i.
REQ-021 If memread_i and memwrite_i are both 1, the op SHALL be treated as a store (dWEN only).
REQ-022 IDLE with no mop and no valid halt: dREN=dWEN=0, mwen=1, mwflush=0, stall_o=0.
REQ-023 IDLE with mop: dREN/dWEN SHALL be driven combinationally from the inputs in the same cycle.
REQ-024 IDLE with mop and dhit=1: single-cycle completion; mwen=1, mwflush=0, stall_o=0; stay in IDLE; the matching counter increments.
REQ-025 IDLE with mop and dhit=0: the op type is latched; mwen=1, mwflush=1, stall_o=1; go to ACCESS; wait_cnt loads 1.
REQ-026 ACCESS: dREN/dWEN SHALL be driven from the latched op, not from the inputs.
REQ-027 ACCESS with dhit=0: mwen=1, mwflush=1, stall_o=1; wait_cnt increments and saturates at all-ones.
REQ-028 ACCESS with dhit=1: mwen=1, mwflush=0, stall_o=0; go to IDLE; ld_cnt or st_cnt increments.
REQ-029 On single-cycle completion from IDLE, wait_cnt SHALL clear to 0.
REQ-030 ld_cnt and st_cnt SHALL wrap modulo 2^CNT_W.
REQ-031 IDLE with valid_i & halt_i: mwen=1, mwflush=0, stall_o=0 so the halt enters MEM/WB; go to HALTED.
REQ-032 HALTED: halt_o=1, stall_o=1, mwen=0, dREN=dWEN=0; all inputs including dhit are ignored; only RST exits this state.
REQ-033 halt_i is not sampled in ACCESS; the instruction in EX/MEM is frozen by stall_o.
REQ-034 dhit SHALL be ignored in IDLE when there is no mop.
REQ-035 Across the complete output set, at most one of dREN and dWEN SHALL be 1 in any cycle.

Reset
REQ-036 While RST=1, asynchronously: state=IDLE, latched op cleared, ld_cnt=st_cnt=0, wait_cnt=0, halt_o=0.
REQ-037 Assertion of RST during ACCESS SHALL abandon the access; dREN/dWEN SHALL be 0 in the first cycle after deassertion unless a new mop is present.
REQ-038 Assertion of RST in HALTED SHALL return the block to IDLE with halt_o=0.

Verification
REQ-039 Load, hit case: valid_i=1, memread_i=1, dhit=1 -> dREN=1, mwen=1, mwflush=0, stall_o=0 that cycle; ld_cnt 0->1; wait_cnt=0.
REQ-040 Store, miss case: valid_i=1, memwrite_i=1, dhit=0 for 3 cycles then 1 -> dWEN=1 for 4 cycles, stall_o=1 and mwflush=1 for 3 cycles, then IDLE; st_cnt=1; wait_cnt=3.
REQ-041 Halt: valid_i=1, halt_i=1 -> mwen=1 for one cycle; then halt_o=1, stall_o=1, mwen=0; a later dhit and mop are ignored for 10 cycles.
REQ-042 Saturation and conflict: WAIT_W=8, load with dhit=0 for 300 cycles -> wait_cnt holds 255; memread_i=memwrite_i=1 -> dWEN=1, dREN=0, st_cnt increments.
REQ-043 Reset mid-access: RST pulsed in cycle 2 of a load miss -> immediate IDLE, counters=0, dREN=0 after release with valid_i=0.
REQ-044 Wrap: CNT_W=4, 17 single-cycle loads -> ld_cnt=1.
